// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption sequencer: initial AddRoundKey in-house, then NR passes through an
// external round datapath with round keys fetched by index from the key-schedule store.
module aes_round_ctrl #(
  parameter int unsigned NR            = 10,
  parameter int unsigned ROUND_LATENCY = 1
) (
  input  logic         i_aes_ctrl_clk,
  input  logic         i_aes_ctrl_rst_n,
  input  logic         i_aes_ctrl_in_valid,
  output logic         o_aes_ctrl_in_ready,
  input  logic [127:0] i_aes_ctrl_data_in,
  output logic [3:0]   o_aes_ctrl_key_idx,
  input  logic [127:0] i_aes_ctrl_key_data,
  output logic [127:0] o_aes_ctrl_round_data,
  output logic [127:0] o_aes_ctrl_round_key,
  output logic         o_aes_ctrl_round_last,
  input  logic [127:0] i_aes_ctrl_round_result,
  output logic         o_aes_ctrl_out_valid,
  input  logic         i_aes_ctrl_out_ready,
  output logic [127:0] o_aes_ctrl_data_out,
  output logic         o_aes_ctrl_busy
);

  localparam logic [3:0] NrL  = 4'(NR);
  localparam logic [1:0] LatL = 2'(ROUND_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} st_e;

  st_e          st_q, st_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   lat_q, lat_d;
  logic [127:0] state_q, state_d;
  logic [127:0] dout_q, dout_d;

  always_ff @(posedge i_aes_ctrl_clk or negedge i_aes_ctrl_rst_n) begin
    if (!i_aes_ctrl_rst_n) begin
      st_q    <= StIdle;
      round_q <= 4'd0;
      lat_q   <= 2'd0;
      state_q <= '0;
      dout_q  <= '0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      lat_q   <= lat_d;
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    st_d                  = st_q;
    round_d               = round_q;
    lat_d                 = lat_q;
    state_d               = state_q;
    dout_d                = dout_q;
    o_aes_ctrl_in_ready   = 1'b0;
    o_aes_ctrl_out_valid  = 1'b0;
    o_aes_ctrl_key_idx    = 4'd0;
    o_aes_ctrl_round_last = 1'b0;

    case (st_q)
      StIdle: begin
        o_aes_ctrl_in_ready = 1'b1;
        // Key index 0 is presented here, so key_data is round key 0.
        if (i_aes_ctrl_in_valid) begin
          state_d = i_aes_ctrl_data_in ^ i_aes_ctrl_key_data;
          round_d = 4'd1;
          st_d    = StIssue;
        end
      end
      StIssue: begin
        o_aes_ctrl_key_idx    = round_q;
        o_aes_ctrl_round_last = (round_q == NrL);
        lat_d                 = LatL;
        st_d                  = StWait;
      end
      StWait: begin
        // Key and last flag stay put: the datapath applies the key after its internal register.
        o_aes_ctrl_key_idx    = round_q;
        o_aes_ctrl_round_last = (round_q == NrL);
        lat_d                 = lat_q - 2'd1;
        if (lat_q == 2'd1) begin
          state_d = i_aes_ctrl_round_result;
          if (round_q < NrL) begin
            round_d = round_q + 4'd1;
            st_d    = StIssue;
          end else begin
            dout_d = i_aes_ctrl_round_result;
            st_d   = StDone;
          end
        end
      end
      StDone: begin
        o_aes_ctrl_out_valid = 1'b1;
        if (i_aes_ctrl_out_ready) st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
  end

  assign o_aes_ctrl_round_data = state_q;
  assign o_aes_ctrl_round_key  = i_aes_ctrl_key_data;
  assign o_aes_ctrl_data_out   = dout_q;
  assign o_aes_ctrl_busy       = (st_q != StIdle);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (AES-128/latency 1, AES-256/latency 2), each with a
// behavioural round datapath and key store, checked against FIPS-197 vectors via a scoreboard.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NR=10, ROUND_LATENCY=1
  logic         in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [127:0] data_in_a = '0;
  logic         in_ready_a, round_last_a, out_valid_a, busy_a;
  logic [3:0]   key_idx_a;
  logic [127:0] key_data_a, round_data_a, round_key_a, round_result_a, data_out_a;

  // Instance B: NR=14, ROUND_LATENCY=2
  logic         in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [127:0] data_in_b = '0;
  logic         in_ready_b, round_last_b, out_valid_b, busy_b;
  logic [3:0]   key_idx_b;
  logic [127:0] key_data_b, round_data_b, round_key_b, round_result_b, data_out_b;

  aes_round_ctrl #(.NR(10), .ROUND_LATENCY(1)) dut (
    .i_aes_ctrl_clk          (clk),
    .i_aes_ctrl_rst_n        (rst_n),
    .i_aes_ctrl_in_valid     (in_valid_a),
    .o_aes_ctrl_in_ready     (in_ready_a),
    .i_aes_ctrl_data_in      (data_in_a),
    .o_aes_ctrl_key_idx      (key_idx_a),
    .i_aes_ctrl_key_data     (key_data_a),
    .o_aes_ctrl_round_data   (round_data_a),
    .o_aes_ctrl_round_key    (round_key_a),
    .o_aes_ctrl_round_last   (round_last_a),
    .i_aes_ctrl_round_result (round_result_a),
    .o_aes_ctrl_out_valid    (out_valid_a),
    .i_aes_ctrl_out_ready    (out_ready_a),
    .o_aes_ctrl_data_out     (data_out_a),
    .o_aes_ctrl_busy         (busy_a)
  );

  aes_round_ctrl #(.NR(14), .ROUND_LATENCY(2)) dut14 (
    .i_aes_ctrl_clk          (clk),
    .i_aes_ctrl_rst_n        (rst_n),
    .i_aes_ctrl_in_valid     (in_valid_b),
    .o_aes_ctrl_in_ready     (in_ready_b),
    .i_aes_ctrl_data_in      (data_in_b),
    .o_aes_ctrl_key_idx      (key_idx_b),
    .i_aes_ctrl_key_data     (key_data_b),
    .o_aes_ctrl_round_data   (round_data_b),
    .o_aes_ctrl_round_key    (round_key_b),
    .o_aes_ctrl_round_last   (round_last_b),
    .i_aes_ctrl_round_result (round_result_b),
    .o_aes_ctrl_out_valid    (out_valid_b),
    .i_aes_ctrl_out_ready    (out_ready_b),
    .o_aes_ctrl_data_out     (data_out_b),
    .o_aes_ctrl_busy         (busy_b)
  );

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox [256];
  logic [127:0] keys_a [16];
  logic [127:0] keys_b [16];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Multiplicative inverse as x^254, then the affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] r = 8'h01, base = x, e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to_b);
    logic [31:0] w [60];
    logic [31:0] temp;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      temp = w[i-1];
      if (i % nk == 0) begin
        temp = subw({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        temp = subw(temp);
      end
      w[i] = w[i-nk] ^ temp;
    end
    for (int r = 0; r < 16; r++) begin
      if (r <= nr) begin
        if (to_b) keys_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        else      keys_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end else begin
        if (to_b) keys_b[r] = '0;
        else      keys_a[r] = '0;
      end
    end
  endtask

  function automatic logic [127:0] encrypt_a(input logic [127:0] pt);
    logic [127:0] s = pt ^ keys_a[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, keys_a[r], r == 10);
    return s;
  endfunction

  // Key stores (combinational) and round datapaths (pipelined by ROUND_LATENCY).
  assign key_data_a = keys_a[key_idx_a];
  assign key_data_b = keys_b[key_idx_b];

  logic [127:0] pipe_a, pipe_b0, pipe_b1;
  always_ff @(posedge clk) begin
    pipe_a  <= aes_round(round_data_a, round_key_a, round_last_a);
    pipe_b0 <= aes_round(round_data_b, round_key_b, round_last_b);
    pipe_b1 <= pipe_b0;
  end
  assign round_result_a = pipe_a;
  assign round_result_b = pipe_b1;

  // ---------------- Checking infrastructure ----------------
  logic sel = 1'b0;  // 0: instance A, 1: instance B
  logic         o_in_ready, o_out_valid, o_busy, o_last;
  logic [3:0]   o_idx;
  logic [127:0] o_rdata, o_dout;
  assign o_in_ready  = sel ? in_ready_b   : in_ready_a;
  assign o_out_valid = sel ? out_valid_b  : out_valid_a;
  assign o_busy      = sel ? busy_b       : busy_a;
  assign o_last      = sel ? round_last_b : round_last_a;
  assign o_idx       = sel ? key_idx_b    : key_idx_a;
  assign o_rdata     = sel ? round_data_b : round_data_a;
  assign o_dout      = sel ? data_out_b   : data_out_a;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] d);
    if (sel) begin in_valid_b = v; data_in_b = d; end
    else     begin in_valid_a = v; data_in_a = d; end
  endtask

  task automatic set_ready(input logic r);
    if (sel) out_ready_b = r;
    else     out_ready_a = r;
  endtask

  // One full transaction from an IDLE negedge; ends at the IDLE negedge after the handshake.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int stall,
                           input int poke_at);
    int nr_c, lat_c, total;
    logic [3:0] rnd;
    logic [127:0] exp;
    nr_c  = sel ? 14 : 10;
    lat_c = sel ? 2 : 1;
    total = nr_c * (1 + lat_c);
    drive(1'b1, pt);
    set_ready(stall == 0);
    chk("accept_ready", 128'(o_in_ready), 128'd1);
    chk("accept_idx", 128'(o_idx), 128'd0);
    sb.push_back(ct);
    @(negedge clk);
    drive(1'b0, pt);
    for (int j = 0; j < total; j++) begin
      rnd = 4'(j / (1 + lat_c) + 1);
      chk("round_seq", 128'({o_busy, o_in_ready, o_out_valid, o_last, o_idx}),
          128'({1'b1, 1'b0, 1'b0, rnd == 4'(nr_c), rnd}));
      if (j == poke_at) drive(1'b1, ~pt);
      else              drive(1'b0, pt);
      @(negedge clk);
    end
    drive(1'b0, pt);
    chk("done_valid", 128'({o_busy, o_in_ready, o_out_valid, o_last}), 128'(4'b1010));
    for (int s = 0; s < stall; s++) begin
      chk("stall_flags", 128'({o_in_ready, o_out_valid}), 128'(2'b01));
      chk("stall_data", o_dout, ct);
      @(negedge clk);
    end
    set_ready(1'b1);
    chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
    exp = sb.pop_front();
    chk("ciphertext", o_dout, exp);
    @(negedge clk);
    chk("back_idle", 128'({o_busy, o_in_ready, o_out_valid}), 128'(3'b010));
  endtask

  localparam logic [127:0] PtC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CtC3   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] Key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] Key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0] rnd_pt;
    for (int i = 0; i < 256; i++) sbox[i] = sbox_f(8'(i));
    expand(Key128, 4, 10, 1'b0);
    expand(Key256, 8, 14, 1'b1);

    // Reset values on both instances
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("reset_flags", 128'({o_busy, o_in_ready, o_out_valid, o_last, o_idx}), 128'(8'h40));
      chk("reset_rdata", o_rdata, '0);
      chk("reset_dout", o_dout, '0);
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with key-index sequence, back-to-back with a stalled block plus busy poke
    run_block(PtC, CtC1, 0, -1);
    run_block(PtC, CtC1, 7, 5);
    // Accepted one cycle after the handshake: random plaintext
    rnd_pt = {$urandom, $urandom, $urandom, $urandom};
    run_block(rnd_pt, encrypt_a(rnd_pt), 0, -1);

    // Reset during round 4 abandons the block
    drive(1'b1, PtC);
    set_ready(1'b1);
    @(negedge clk);
    drive(1'b0, PtC);
    repeat (6) @(negedge clk);
    chk("pre_reset_round", 128'(o_idx), 128'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 128'({o_busy, o_in_ready, o_out_valid, o_last, o_idx}), 128'(8'h40));
    chk("midrst_rdata", o_rdata, '0);
    chk("midrst_dout", o_dout, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 128'({o_busy, o_in_ready, o_out_valid}), 128'(3'b010));
    run_block(PtC, CtC1, 0, -1);

    // NR=14, ROUND_LATENCY=2 against FIPS-197 C.3
    sel = 1'b1;
    @(negedge clk);
    run_block(PtC, CtC3, 2, 9);

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
- Iterative AES encryption sequencer. Accepts one 128-bit plaintext block per transaction and performs the initial AddRoundKey itself.
- Drives a shared external round datapath once per round (NR rounds), fetches each round key by index from the key-schedule store, and returns the ciphertext on a valid/ready output.
- Sits between the block-level input/output interface and the round datapath plus key RAM.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12 and 14; any other value is illegal.
- ROUND_LATENCY, 1, cycles from the round input being driven to the round result being valid. Legal range is 1–3.

Ports:
- i_aes_ctrl_clk  input  1  clock; all logic on the rising edge
- i_aes_ctrl_rst_n  input  1  asynchronous active-low reset
- i_aes_ctrl_in_valid  input  1  plaintext valid
- o_aes_ctrl_in_ready  output  1  controller can accept a block
- i_aes_ctrl_data_in  input  128  plaintext
- o_aes_ctrl_key_idx  output  4  round-key index into the key store
- i_aes_ctrl_key_data  input  128  round key; combinational return for o_aes_ctrl_key_idx
- o_aes_ctrl_round_data  output  128  state presented to the round datapath
- o_aes_ctrl_round_key  output  128  round key presented to the datapath
- o_aes_ctrl_round_last  output  1  final round; the datapath must bypass MixColumns
- i_aes_ctrl_round_result  input  128  round datapath output
- o_aes_ctrl_out_valid  output  1  ciphertext valid
- i_aes_ctrl_out_ready  input  1  consumer accepts ciphertext
- o_aes_ctrl_data_out  output  128  ciphertext
- o_aes_ctrl_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE; round counter, latency counter, state register and o_aes_ctrl_data_out are cleared to 0.
  - Output values during reset: in_ready=1, out_valid=0, busy=0, key_idx=0, round_last=0, round_data=0.
- Reset mid-operation abandons the block. No output is produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1 and key_idx=0.
  - On in_valid&&in_ready: state <= data_in ^ key_data (initial AddRoundKey), round <= 1, next state ISSUE.
- ISSUE, one cycle:
  - round_data = state.
  - key_idx = round.
  - round_last = (round==NR).
  - Latency counter is loaded with ROUND_LATENCY. Next state WAIT.
- WAIT, ROUND_LATENCY cycles:
  - key_idx, round_last and round_data are held stable, because the datapath applies the key after its internal register.
  - Counter decrements each cycle. On the cycle it reads 1, state <= round_result.
  - If round<NR: round++, next state ISSUE.
  - Else: data_out <= round_result, next state DONE.
- DONE:
  - out_valid=1. data_out is held stable while out_valid && !out_ready.
  - On out_ready: next state IDLE, out_valid falls the next cycle.
- in_ready is 0 in every state except IDLE. in_valid outside IDLE is ignored; no buffering.
- Round timing: each round takes 1+ROUND_LATENCY cycles. out_valid first rises NR*(1+ROUND_LATENCY) cycles after the accept edge, which is 20 cycles at the defaults.
- Block-to-block spacing: the minimum accept-to-accept spacing is NR*(1+ROUND_LATENCY)+2 cycles (one DONE handshake cycle plus one IDLE cycle).
- Round counter is 4 bits. It never wraps, since the maximum value is 14.
- Outside ISSUE/WAIT: round_data and round_key are don't-care, but round_last must be 0.
- o_aes_ctrl_round_key = i_aes_ctrl_key_data, a passthrough.

Test Plan:
- FIPS-197 C.1: key store holds the expanded key from key 000102…0f; plaintext 00112233445566778899aabbccddeeff; out_ready=1 → out_valid after exactly 20 cycles, data_out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- Key-index sequence: monitor key_idx over the FIPS-197 C.1 run → sequence 0 (at accept), then 1..10, each held for 2 cycles; round_last high only during round 10.
- Backpressure: out_ready=0 for 7 cycles after out_valid → data_out stable and in_ready=0 throughout; then out_ready=1 → IDLE next cycle; a new block is accepted one cycle later.
- Busy rejection: pulse in_valid with a different plaintext at cycle 5 of processing → ignored; ciphertext is unchanged.
- Reset mid-operation: assert rst_n=0 during round 4 → outputs immediately go to their reset values; after release, a fresh FIPS-197 C.1 block gives the correct ciphertext.
- Parameter sweep: NR=14 with ROUND_LATENCY=2 against the FIPS-197 C.3 AES-256 vector → data_out = 8ea2b7ca516745bfeafc49904b496089 after 42 cycles.
